pipelined_adder: RTL
====================

# pipelined_adder

Parametrised, pipelined ripple-carry adder/subtractor. The operand width is split into `STAGES` equal chunks, and one chunk is resolved per pipeline stage, with the carry registered between stages. Throughput is one result per cycle under valid/ready flow control with per-stage bubble collapsing. It replaces fixed-width combinational ripple adders on datapaths where the full carry chain cannot close timing in one cycle.

## Interface
- `WIDTH`, 32: operand and sum width in bits; must be ≥ 2.
- `STAGES`, 4: number of pipeline stages; 1 ≤ `STAGES` ≤ `WIDTH`. `WIDTH % STAGES` must equal 0. Chunk width is `CW = WIDTH/STAGES`.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous reset, active-low.
- `in_valid` input 1: an operand set is presented.
- `in_ready` output 1: the block accepts the operand set this cycle.
- `a` input `WIDTH`: operand A (unsigned or two's complement).
- `b` input `WIDTH`: operand B.
- `cin` input 1: carry-in, used only when `sub`=0.
- `sub` input 1: 0 → a+b+cin; 1 → a−b (a+~b+1; `cin` ignored).
- `out_valid` output 1: result is valid.
- `out_ready` input 1: downstream accepts the result.
- `sum` output `WIDTH`: result, modulo 2^`WIDTH`.
- `cout` output 1: carry-out of the MSB. In subtract mode, 1 means no borrow (a ≥ b unsigned).
- `overflow` output 1: signed overflow of the operation.

## Operation
- Stage register k (k = 0..`STAGES`−1) holds:
  - valid bit `v[k]`;
  - resolved low bits [(k+1)·CW−1:0];
  - unresolved high bits of a and b′, where b′ = `sub` ? ~b : b;
  - carry out of chunk k;
  - the MSB of a and of b′, kept for overflow.
- Stage 0 computes chunk 0 from a, b′ and c0 = `sub` ? 1 : `cin`.
- Stage k computes chunk k from the forwarded operand bits and the carry held in stage k−1. The add inside a chunk is a plain ripple (sum = x^y^c, carry = majority).
- The final stage drives `sum`, `cout`, `overflow` and `out_valid` directly from registers; there is no output logic after the flops.
- `overflow` = (a_msb == b′_msb) && (sum_msb != a_msb).
- Flow control, with `ready[STAGES]` = `out_ready`:
  - `ready[k]` = !`v[k]` || `ready[k+1]`;
  - `in_ready` = `ready[0]` && `rst_n`.
- Stage k loads when `ready[k]` is high. It loads from stage k−1, or from the inputs when k = 0. The loaded valid bit is `v[k−1]`, or `in_valid` for k = 0.
- A transfer occurs on `in_valid` && `in_ready`, and likewise on `out_valid` && `out_ready`.
- A stage that is not loading holds all of its contents.
- Bubbles collapse: an empty stage accepts even when downstream is stalled.
- `in_ready` depends combinationally on `out_ready` through the ready chain. This is the only combinational input-to-output path.
- Reset:
  - All `v[k]`, data and carry registers go to 0.
  - Outputs during and after reset: `out_valid`=0, `sum`=0, `cout`=0, `overflow`=0, `in_ready`=0 while `rst_n` is low.
  - Reset mid-operation discards all in-flight results, with no partial outputs.
- Results leave in acceptance order. No operand set is dropped or duplicated.

## Timing
- Latency: `STAGES` cycles. An operand accepted at edge n has `out_valid`=1 after edge n+`STAGES−1`, i.e. the result is visible in cycle n+`STAGES`, provided there is no stall.
- `STAGES`=1 gives a single registered full-width adder with 1-cycle latency.
- Throughput is 1 per cycle while `out_ready`=1.
- The output is stable while `out_valid` && !`out_ready`: `sum`, `cout` and `overflow` do not change.
- When full and stalled, `in_ready`=0. After `out_ready` rises, `in_ready`=1 in the same cycle, because the ready chain is combinational.
- Capacity is exactly `STAGES` results in flight. After `STAGES` accepts with `out_ready` held at 0, `in_ready`=0.
- Simultaneous accept and drain when full: both transfers occur in the same cycle.
- Reset release: the first accept is possible on the first edge after `rst_n` rises.

## Test plan
- **Basic add**, `WIDTH`=8, `STAGES`=4, `sub`=0: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0, exactly 4 cycles after accept.
- **Subtract with borrow**, `WIDTH`=8, `STAGES`=4: a=0x05, b=0x07, sub=1, cin=1 → sum=0xFE, cout=0, overflow=0. Then a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, overflow=1.
- **Full-rate streaming**, `WIDTH`=32, `STAGES`=4: 1000 random back-to-back ops with `out_ready`=1 and mixed `sub`/`cin` → one result per cycle, in order, matching a reference model bit-exactly.
- **Backpressure**, `WIDTH`=8, `STAGES`=4: hold `out_ready`=0 and offer 6 ops → exactly 4 accepted, `in_ready`=0, and `sum` stable. Then `out_ready`=1 → the 4 results drain in order and the remaining 2 are accepted.
- **Bubble collapse**, `WIDTH`=8, `STAGES`=4: accept 1 op, 2 idle cycles, accept 1 op, with `out_ready`=0 → both are held in the last 2 stages and `in_ready` stays 1 until 4 ops are in flight.
- **Reset mid-flight**: with 3 ops in flight, pulse `rst_n` low asynchronously between edges → `out_valid`=0 immediately. No stale result appears after release, and the next op returns after 4 cycles. Repeat the streaming check at `STAGES`=1 and `STAGES`=8.

Source files
------------

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder
// Description : Pipelined ripple-carry adder/subtractor. The operand is cut
//               into STAGES equal chunks of CW = WIDTH/STAGES bits. Each
//               pipeline stage resolves one chunk and registers the carry
//               that feeds the next chunk. Valid/ready flow control runs at
//               one result per cycle, and empty stages collapse even when the
//               output is stalled.
//
// Parameters  : WIDTH   operand/sum width (>= 2)
//               STAGES  pipeline depth (1..WIDTH, WIDTH % STAGES == 0)
//
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               in_valid   operand set presented
//               in_ready   operand set accepted this cycle
//               a, b       operands (unsigned or two's complement)
//               cin        carry-in (add mode only)
//               sub        0: a+b+cin   1: a-b
//               out_valid  result valid
//               out_ready  downstream accepts result
//               sum        result modulo 2^WIDTH
//               cout       MSB carry-out (subtract: 1 = no borrow)
//               overflow   signed overflow
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = WIDTH / STAGES;

  // Pipeline boundary k is the input of stage k; boundary 0 is the block
  // input, boundary STAGES is the output register of the last stage.
  //   w_x : resolved sum bits below the current chunk, raw a bits above it
  //   w_y : b' bits not yet consumed (consumed chunks are cleared)
  //   w_c : carry into the chunk resolved by the next stage
  logic [STAGES:0]  w_v;
  logic [STAGES:0]  w_c;
  logic [WIDTH-1:0] w_x [STAGES+1];
  logic [WIDTH-1:0] w_y [STAGES+1];
  logic [STAGES:0]  w_ready;
  logic             w_ovf;

  // Plain bit-serial ripple over one chunk: returns {carry_out, sum}.
  function automatic logic [CW:0] chunk_add(
    input logic [CW-1:0] x,
    input logic [CW-1:0] y,
    input logic          c
  );
    logic [CW-1:0] s;
    logic          cc;
    s  = '0;
    cc = c;
    for (int i = 0; i < CW; i++) begin
      s[i] = x[i] ^ y[i] ^ cc;
      cc   = (x[i] & y[i]) | (x[i] & cc) | (y[i] & cc);
    end
    return {cc, s};
  endfunction

  // Subtraction is a + ~b + 1, so the carry-in is forced high and cin is
  // ignored in that mode.
  assign w_v[0] = in_valid;
  assign w_x[0] = a;
  assign w_y[0] = sub ? ~b : b;
  assign w_c[0] = sub | cin;

  // Ready chain from the output back to the input. A stage is ready when it
  // is empty or its successor is ready, so bubbles are squeezed out even
  // while out_ready is low.
  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ready[k] = ~w_v[k+1] | w_ready[k+1];
    end
  end

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             r_v;
      logic             r_c;
      logic [WIDTH-1:0] r_x;
      logic [WIDTH-1:0] r_y;

      logic [CW-1:0]    w_s;
      logic             w_co;
      logic [WIDTH-1:0] w_x_n;
      logic [WIDTH-1:0] w_y_n;
      logic             w_load;

      always_comb begin
        {w_co, w_s}        = chunk_add(w_x[k][k*CW +: CW], w_y[k][k*CW +: CW], w_c[k]);
        w_x_n              = w_x[k];
        w_x_n[k*CW +: CW]  = w_s;
        w_y_n              = w_y[k];
        w_y_n[k*CW +: CW]  = '0;
      end

      // Data registers only move when a real operand is arriving; a bubble
      // clears the valid bit but leaves the data alone, which keeps the
      // outputs quiet (zero after reset) while nothing valid is present.
      assign w_load = w_ready[k] & w_v[k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v <= 1'b0;
          r_c <= 1'b0;
          r_x <= '0;
          r_y <= '0;
        end else begin
          if (w_ready[k]) begin
            r_v <= w_v[k];
          end
          if (w_load) begin
            r_x <= w_x_n;
            r_y <= w_y_n;
            r_c <= w_co;
          end
        end
      end

      assign w_v[k+1] = r_v;
      assign w_c[k+1] = r_c;
      assign w_x[k+1] = r_x;
      assign w_y[k+1] = r_y;

      // Overflow is decided while the top chunk is being resolved: the MSBs
      // of a and b' are still present at this stage's input, so the flag can
      // be registered alongside the sum with no logic after the flops.
      if (k == STAGES - 1) begin : g_last
        logic r_ovf;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_ovf <= 1'b0;
          end else if (w_load) begin
            r_ovf <= (w_x[k][WIDTH-1] == w_y[k][WIDTH-1]) &&
                     (w_s[CW-1] != w_x[k][WIDTH-1]);
          end
        end

        assign w_ovf = r_ovf;
      end
    end
  endgenerate

  // in_ready is forced low during reset so nothing is accepted into a
  // pipeline that is being cleared.
  assign in_ready  = w_ready[0] & rst_n;
  assign out_valid = w_v[STAGES];
  assign sum       = w_x[STAGES];
  assign cout      = w_c[STAGES];
  assign overflow  = w_ovf;

endmodule
`default_nettype wire
